// File: rtl/noc_pkg.sv
// Shared NoC definitions for the PageRank fetch side: request encoding,
// response field layout and the gather controller state type.
package noc_pkg;

    localparam logic [5:0] REQ_IDLE     = 6'd0;
    localparam int         RSP_ID_W     = 6;
    localparam int         RSP_ID_LSB   = 0;
    localparam int         RSP_DATA_LSB = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/rank_scoreboard.sv
// Outstanding-request table: allocate lowest free entry, retire lowest
// matching entry, flush on abort. Duplicate ids are allowed.
module rank_scoreboard
    import noc_pkg::*;
#(
    parameter int MAX_OUT = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alloc_en,
    input  logic [RSP_ID_W-1:0] alloc_id,
    input  logic                match_en,
    input  logic [RSP_ID_W-1:0] match_id,
    input  logic                flush,
    output logic                hit,
    output logic                empty,
    output logic                full
);

    logic [MAX_OUT-1:0]  valid_q;
    logic [MAX_OUT-1:0]  valid_d;
    logic [MAX_OUT-1:0]  match_vec;
    logic [MAX_OUT-1:0]  match_pick;
    logic [MAX_OUT-1:0]  free_pick;
    logic [RSP_ID_W-1:0] id_q [MAX_OUT];
    logic [RSP_ID_W-1:0] id_d [MAX_OUT];

    genvar gi;
    generate
        for (gi = 0; gi < MAX_OUT; gi++) begin : g_cmp
            assign match_vec[gi] = valid_q[gi] && (id_q[gi] == match_id);
        end
    endgenerate

    // x & -x isolates the lowest set bit; both picks see start-of-cycle state.
    assign free_pick  = ~valid_q & (valid_q + MAX_OUT'(1));
    assign match_pick = match_vec & (~match_vec + MAX_OUT'(1));
    assign hit        = |match_vec;
    assign empty      = ~|valid_q;
    assign full       = &valid_q;

    always_comb begin
        valid_d = valid_q;
        id_d    = id_q;
        if (match_en) begin
            valid_d = valid_d & ~match_pick;
        end
        if (alloc_en) begin
            valid_d = valid_d | free_pick;
            for (int i = 0; i < MAX_OUT; i++) begin
                if (free_pick[i]) begin
                    id_d[i] = alloc_id;
                end
            end
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        id_q <= id_d;
    end

endmodule

// File: rtl/rank_gather.sv
// Per-cluster PageRank fetch controller: issues a batch of page ids onto the
// NoC, matches replies against a scoreboard and returns one saturated sum.
module rank_gather
    import noc_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int MAX_OUT = 8,
    parameter int ACC_W   = DATA_W + 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [5:0]           cmd_page,
    input  logic                 cmd_last,
    output logic [5:0]           request,
    input  logic                 resp_valid,
    input  logic [DATA_W+5:0]    response,
    output logic                 sum_valid,
    input  logic                 sum_ready,
    output logic [ACC_W-1:0]     sum,
    output logic [6:0]           sum_count,
    output logic                 timeout_err,
    output logic                 unexpected_err
);

    localparam int              IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);
    localparam logic [6:0]      COUNT_MAX = 7'h7F;

    state_e              state_q, state_d;
    logic                alive_q;
    logic [5:0]          request_q, request_d;
    logic [ACC_W-1:0]    sum_q, sum_d;
    logic [6:0]          count_q, count_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic                terr_q, terr_d;
    logic                uerr_q, uerr_d;

    logic                cmd_fire;
    logic                rsp_active;
    logic                match_fire;
    logic                sb_hit, sb_empty, sb_full, sb_flush;
    logic [DATA_W-1:0]   reply;
    logic [RSP_ID_W-1:0] rsp_id;
    logic [ACC_W:0]      sum_wide;

    assign reply      = response[RSP_DATA_LSB +: DATA_W];
    assign rsp_id     = response[RSP_ID_LSB +: RSP_ID_W];
    assign rsp_active = resp_valid && (state_q == ST_ISSUE || state_q == ST_DRAIN);
    assign match_fire = rsp_active && sb_hit;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign sum_wide   = (ACC_W + 1)'(sum_q) + (ACC_W + 1)'(reply);

    rank_scoreboard #(
        .MAX_OUT (MAX_OUT)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .alloc_en (cmd_fire),
        .alloc_id (cmd_page),
        .match_en (rsp_active),
        .match_id (rsp_id),
        .flush    (sb_flush),
        .hit      (sb_hit),
        .empty    (sb_empty),
        .full     (sb_full)
    );

    // alive_q holds cmd_ready low for the first cycle after reset.
    always_comb begin
        cmd_ready = 1'b0;
        if (alive_q) begin
            case (state_q)
                ST_IDLE:  cmd_ready = 1'b1;
                ST_ISSUE: cmd_ready = !sb_full;
                default:  cmd_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        request_d = cmd_fire ? cmd_page : REQ_IDLE;
        sum_d     = sum_q;
        count_d   = count_q;
        idle_d    = idle_q;
        terr_d    = terr_q;
        uerr_d    = uerr_q;
        sb_flush  = 1'b0;

        if (resp_valid && !match_fire) begin
            uerr_d = 1'b1;
        end
        if (match_fire) begin
            sum_d   = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
            count_d = (count_q == COUNT_MAX) ? count_q : count_q + 7'd1;
        end

        if (cmd_fire || match_fire) begin
            idle_d = '0;
        end else if (state_q == ST_DRAIN && idle_q != IDLE_MAX) begin
            idle_d = idle_q + IDLE_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    sum_d   = '0;
                    count_d = '0;
                    state_d = cmd_last ? ST_DRAIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_fire && cmd_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A reply matched in the abort cycle is already folded into sum_d.
                if (sb_empty) begin
                    state_d = ST_DONE;
                end else if (idle_q == IDLE_MAX) begin
                    terr_d   = 1'b1;
                    sb_flush = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            default: begin
                if (sum_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            alive_q   <= 1'b0;
            request_q <= REQ_IDLE;
            sum_q     <= '0;
            count_q   <= '0;
            idle_q    <= '0;
            terr_q    <= 1'b0;
            uerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            alive_q   <= 1'b1;
            request_q <= request_d;
            sum_q     <= sum_d;
            count_q   <= count_d;
            idle_q    <= idle_d;
            terr_q    <= terr_d;
            uerr_q    <= uerr_d;
        end
    end

    assign request        = request_q;
    assign sum_valid      = (state_q == ST_DONE);
    assign sum            = sum_q;
    assign sum_count      = count_q;
    assign timeout_err    = terr_q;
    assign unexpected_err = uerr_q;

endmodule

// File: tb/tb_rank_gather.sv
// Directed bench for rank_gather: hand-computed sums, counts, flags and
// cycle positions for each batch scenario.
module tb_rank_gather;

    localparam int DATA_W  = 16;
    localparam int ACC_W   = 20;
    localparam int TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [5:0]        cmd_page;
    logic              cmd_last;
    logic [5:0]        request;
    logic              resp_valid;
    logic [DATA_W+5:0] response;
    logic              sum_valid;
    logic              sum_ready;
    logic [ACC_W-1:0]  sum;
    logic [6:0]        sum_count;
    logic              timeout_err;
    logic              unexpected_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rank_gather #(
        .DATA_W  (DATA_W),
        .MAX_OUT (8),
        .ACC_W   (ACC_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_page       (cmd_page),
        .cmd_last       (cmd_last),
        .request        (request),
        .resp_valid     (resp_valid),
        .response       (response),
        .sum_valid      (sum_valid),
        .sum_ready      (sum_ready),
        .sum            (sum),
        .sum_count      (sum_count),
        .timeout_err    (timeout_err),
        .unexpected_err (unexpected_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One command handshake; request must show the page right after it.
    task automatic send(input logic [5:0] page, input logic last);
        int w;
        w = 0;
        cmd_valid = 1'b1;
        cmd_page  = page;
        cmd_last  = last;
        while (!cmd_ready && w < 20) begin
            tick();
            w++;
        end
        if (w == 20) check_eq("cmd_ready_wait", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        cmd_last  = 1'b0;
        check_eq("request", request, page);
    endtask

    task automatic respond(input logic [5:0] page, input logic [15:0] val);
        resp_valid = 1'b1;
        response   = {val, page};
        tick();
        resp_valid = 1'b0;
    endtask

    task automatic wait_sum(input string tag);
        for (int i = 0; i < 10 && !sum_valid; i++) tick();
        check_eq({tag, "_sum_valid"}, sum_valid, 1);
    endtask

    task automatic take_sum(input string tag);
        $display("batch %s: sum=%0d count=%0d terr=%0b uerr=%0b",
                 tag, sum, sum_count, timeout_err, unexpected_err);
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        check_eq({tag, "_back_idle"}, cmd_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_page   = '0;
        cmd_last   = 1'b0;
        resp_valid = 1'b0;
        response   = '0;
        sum_ready  = 1'b0;
        tick();
        tick();
        check_eq("rst_cmd_ready", cmd_ready, 0);
        check_eq("rst_request", request, 0);
        check_eq("rst_sum_valid", sum_valid, 0);
        check_eq("rst_sum", sum, 0);
        check_eq("rst_count", sum_count, 0);
        check_eq("rst_terr", timeout_err, 0);
        check_eq("rst_uerr", unexpected_err, 0);
        reset = 1'b0;
        check_eq("rst_release_ready", cmd_ready, 0);
        tick();
        check_eq("post_rst_ready", cmd_ready, 1);

        // Single id, reply two cycles after request.
        send(6'd20, 1'b1);
        tick();
        check_eq("single_req_gone", request, 0);
        tick();
        respond(6'd20, 16'd100);
        check_eq("single_sum_t1", sum, 100);
        check_eq("single_cnt_t1", sum_count, 1);
        check_eq("single_valid_t1", sum_valid, 0);
        tick();
        check_eq("single_valid_t2", sum_valid, 1);
        check_eq("single_sum", sum, 100);
        check_eq("single_terr", timeout_err, 0);
        check_eq("single_uerr", unexpected_err, 0);
        take_sum("single");

        // Reply the cycle after request: sum_valid 4 cycles after handshake.
        send(6'd25, 1'b1);
        tick();
        respond(6'd25, 16'd7);
        check_eq("lat_valid_c3", sum_valid, 0);
        tick();
        check_eq("lat_valid_c4", sum_valid, 1);
        check_eq("lat_sum_cleared", sum, 7);
        take_sum("latency");

        // Full pipe: 8 outstanding, ninth waits for the first reply.
        for (int p = 16; p < 24; p++) send(6'(p), 1'b0);
        check_eq("full_ready", cmd_ready, 0);
        cmd_valid = 1'b1;
        cmd_page  = 6'd24;
        cmd_last  = 1'b1;
        tick();
        tick();
        check_eq("full_still_blocked", cmd_ready, 0);
        resp_valid = 1'b1;
        response   = {16'd1600, 6'd16};
        check_eq("full_same_cycle", cmd_ready, 0);
        tick();
        resp_valid = 1'b0;
        check_eq("full_freed", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        cmd_last  = 1'b0;
        check_eq("full_ninth_req", request, 24);
        for (int p = 17; p <= 24; p++) respond(6'(p), 16'(p * 100));
        wait_sum("full");
        check_eq("full_sum", sum, 18000);
        check_eq("full_count", sum_count, 9);
        take_sum("full");

        // Out-of-order replies with a duplicate id.
        send(6'd30, 1'b0);
        send(6'd30, 1'b0);
        send(6'd31, 1'b1);
        respond(6'd31, 16'd5);
        respond(6'd30, 16'd6);
        respond(6'd30, 16'd7);
        wait_sum("dup");
        check_eq("dup_sum", sum, 18);
        check_eq("dup_count", sum_count, 3);
        check_eq("dup_uerr", unexpected_err, 0);
        take_sum("dup");

        // Unexpected reply leaves the real entry pending.
        send(6'd41, 1'b1);
        respond(6'd40, 16'd9);
        check_eq("unexp_flag", unexpected_err, 1);
        check_eq("unexp_sum", sum, 0);
        check_eq("unexp_count", sum_count, 0);
        tick();
        tick();
        check_eq("unexp_pending", sum_valid, 0);
        respond(6'd41, 16'd50);
        wait_sum("unexp");
        check_eq("unexp_final_sum", sum, 50);
        check_eq("unexp_final_cnt", sum_count, 1);
        take_sum("unexp");

        // Timeout: abort decided while the counter holds TIMEOUT, flag
        // visible TIMEOUT+1 edges after the handshake.
        send(6'd50, 1'b1);
        for (int i = 0; i < TIMEOUT; i++) tick();
        check_eq("tmo_early", timeout_err, 0);
        check_eq("tmo_early_valid", sum_valid, 0);
        tick();
        check_eq("tmo_flag", timeout_err, 1);
        check_eq("tmo_valid", sum_valid, 1);
        check_eq("tmo_sum", sum, 0);
        check_eq("tmo_uerr_sticky", unexpected_err, 1);
        take_sum("timeout");

        // Saturation: 16 x FFFF fits, the 17th clamps.
        for (int p = 16; p < 24; p++) send(6'(p), 1'b0);
        for (int p = 16; p < 24; p++) respond(6'(p), 16'hFFFF);
        for (int p = 24; p < 32; p++) send(6'(p), 1'b0);
        for (int p = 24; p < 32; p++) respond(6'(p), 16'hFFFF);
        check_eq("sat_sum16", sum, 20'hFFFF0);
        check_eq("sat_cnt16", sum_count, 16);
        send(6'd32, 1'b1);
        respond(6'd32, 16'hFFFF);
        check_eq("sat_sum17", sum, 20'hFFFFF);
        check_eq("sat_cnt17", sum_count, 17);
        wait_sum("sat");
        take_sum("sat");

        // Reset mid-batch discards outstanding entries and sticky flags.
        send(6'd45, 1'b0);
        send(6'd46, 1'b0);
        reset = 1'b1;
        tick();
        check_eq("mid_rst_ready", cmd_ready, 0);
        check_eq("mid_rst_request", request, 0);
        check_eq("mid_rst_sum", sum, 0);
        check_eq("mid_rst_count", sum_count, 0);
        check_eq("mid_rst_terr", timeout_err, 0);
        check_eq("mid_rst_uerr", unexpected_err, 0);
        reset = 1'b0;
        tick();
        check_eq("mid_rst_back", cmd_ready, 1);
        respond(6'd45, 16'd3);
        check_eq("stale_uerr", unexpected_err, 1);
        check_eq("stale_sum", sum, 0);
        $display("batch reset: stale reply for 45 dropped, uerr=%0b", unexpected_err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
